// File: rtl/regfile_write_queue_pkg.sv
// rtl/regfile_write_queue_pkg.sv - shared widths and constants for the register file write queue
package regfile_write_queue_pkg;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam logic [AW-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wq_entry_t;

endpackage

// File: rtl/regfile_write_queue_if.sv
// rtl/regfile_write_queue_if.sv - request handshake, register file write port and bypass lookups
interface regfile_write_queue_if;
  import regfile_write_queue_pkg::*;

  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  logic          rf_enable;
  logic [AW-1:0] rf_rw;
  logic [DW-1:0] rf_pw;

  logic [AW-1:0] lk_addr_a, lk_addr_b, lk_addr_d;
  logic          lk_hit_a, lk_hit_b, lk_hit_d;
  logic [DW-1:0] lk_data_a, lk_data_b, lk_data_d;

  modport master (
    output wr_valid, wr_addr, wr_data, lk_addr_a, lk_addr_b, lk_addr_d,
    input  wr_ready, rf_enable, rf_rw, rf_pw,
    input  lk_hit_a, lk_hit_b, lk_hit_d, lk_data_a, lk_data_b, lk_data_d
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, lk_addr_a, lk_addr_b, lk_addr_d,
    output wr_ready, rf_enable, rf_rw, rf_pw,
    output lk_hit_a, lk_hit_b, lk_hit_d, lk_data_a, lk_data_b, lk_data_d
  );

endinterface

// File: rtl/regfile_write_queue_lookup.sv
// rtl/regfile_write_queue_lookup.sv - youngest-match search over the pending entries
module wq_lookup
  import regfile_write_queue_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic [AW-1:0] addr_i [DEPTH],
  input  logic [DW-1:0] data_i [DEPTH],
  input  logic [PW-1:0] head_i,
  input  logic [CW-1:0] count_i,
  input  logic [AW-1:0] lk_addr_i,
  output logic          hit_o,
  output logic [DW-1:0] data_o
);

  logic [PW-1:0] idx;

  // Walk oldest to youngest so the last match seen is the youngest one.
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    idx    = head_i;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_i + PW'(k);
      if ((CW'(k) < count_i) && (lk_addr_i != REG_ZERO) && (addr_i[idx] == lk_addr_i)) begin
        hit_o  = 1'b1;
        data_o = data_i[idx];
      end
    end
  end

endmodule

// File: rtl/regfile_write_queue.sv
// rtl/regfile_write_queue.sv - FIFO of pending register writes, drained one per cycle, with read bypass
module regfile_write_queue
  import regfile_write_queue_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   drain_hold_i,
  output logic [CW-1:0]          count_o,
  regfile_write_queue_if.slave   bus
);

  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop, empty;

  assign empty        = (count_q == '0);
  assign bus.wr_ready = (count_q != CW'(DEPTH));
  // Writes to R0 complete the handshake but never occupy a slot.
  assign push         = bus.wr_valid & bus.wr_ready & (bus.wr_addr != REG_ZERO);
  assign pop          = ~empty & ~drain_hold_i;

  assign bus.rf_enable = pop;
  assign bus.rf_rw     = empty ? '0 : addr_q[head_q];
  assign bus.rf_pw     = empty ? '0 : data_q[head_q];
  assign count_o       = count_q;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (pop)  head_d = head_q + PW'(1);
    if (push) tail_d = tail_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (push) begin
        addr_q[tail_q] <= bus.wr_addr;
        data_q[tail_q] <= bus.wr_data;
      end
    end
  end

  wq_lookup #(.DEPTH(DEPTH)) u_lookup_a (
    .addr_i(addr_q), .data_i(data_q), .head_i(head_q), .count_i(count_q),
    .lk_addr_i(bus.lk_addr_a), .hit_o(bus.lk_hit_a), .data_o(bus.lk_data_a)
  );

  wq_lookup #(.DEPTH(DEPTH)) u_lookup_b (
    .addr_i(addr_q), .data_i(data_q), .head_i(head_q), .count_i(count_q),
    .lk_addr_i(bus.lk_addr_b), .hit_o(bus.lk_hit_b), .data_o(bus.lk_data_b)
  );

  wq_lookup #(.DEPTH(DEPTH)) u_lookup_d (
    .addr_i(addr_q), .data_i(data_q), .head_i(head_q), .count_i(count_q),
    .lk_addr_i(bus.lk_addr_d), .hit_o(bus.lk_hit_d), .data_o(bus.lk_data_d)
  );

endmodule

// File: tb/tb_regfile_write_queue.sv
// tb/tb_regfile_write_queue.sv - directed bench with a queue model checked every cycle
module tb_regfile_write_queue;
  import regfile_write_queue_pkg::*;

  localparam int DEPTH = 4;

  logic       clk;
  logic       rst_n;
  logic       drain_hold;
  logic [2:0] count;

  int checks = 0;
  int errors = 0;

  wq_entry_t model[$];
  wq_entry_t clog[$];

  regfile_write_queue_if bus ();

  regfile_write_queue #(.DEPTH(DEPTH)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .drain_hold_i (drain_hold),
    .count_o      (count),
    .bus          (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  function automatic void mlook(input logic [AW-1:0] a, output logic hit, output logic [DW-1:0] d);
    hit = 1'b0;
    d   = '0;
    if (a != 0)
      foreach (model[i])
        if (model[i].addr == a) begin
          hit = 1'b1;
          d   = model[i].data;
        end
  endfunction

  // Mid-cycle compare against the model, then advance the model by this cycle's inputs.
  always @(negedge clk) begin
    logic          h;
    logic [DW-1:0] d;
    logic          mpop, mready;
    if (!rst_n) begin
      model.delete();
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_enable", 64'(bus.rf_enable), 64'd0);
      chk("rst_ready", 64'(bus.wr_ready), 64'd1);
      chk("rst_hit_a", 64'(bus.lk_hit_a), 64'd0);
    end else begin
      mready = (model.size() != DEPTH);
      mpop   = (model.size() != 0) && !drain_hold;
      chk("m_count", 64'(count), 64'(model.size()));
      chk("m_ready", 64'(bus.wr_ready), 64'(mready));
      chk("m_enable", 64'(bus.rf_enable), 64'(mpop));
      chk("m_rw", 64'(bus.rf_rw), model.size() != 0 ? 64'(model[0].addr) : 64'd0);
      chk("m_pw", 64'(bus.rf_pw), model.size() != 0 ? 64'(model[0].data) : 64'd0);
      mlook(bus.lk_addr_a, h, d);
      chk("m_hit_a", 64'(bus.lk_hit_a), 64'(h));
      chk("m_data_a", 64'(bus.lk_data_a), 64'(d));
      mlook(bus.lk_addr_b, h, d);
      chk("m_hit_b", 64'(bus.lk_hit_b), 64'(h));
      chk("m_data_b", 64'(bus.lk_data_b), 64'(d));
      mlook(bus.lk_addr_d, h, d);
      chk("m_hit_d", 64'(bus.lk_hit_d), 64'(h));
      chk("m_data_d", 64'(bus.lk_data_d), 64'(d));
      if (bus.rf_enable) clog.push_back('{addr: bus.rf_rw, data: bus.rf_pw});
      if (mpop) void'(model.pop_front());
      if (bus.wr_valid && mready && bus.wr_addr != 0)
        model.push_back('{addr: bus.wr_addr, data: bus.wr_data});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.wr_valid = v;
    bus.wr_addr  = a;
    bus.wr_data  = d;
  endtask

  initial begin
    rst_n         = 1'b0;
    drain_hold    = 1'b0;
    bus.lk_addr_a = '0;
    bus.lk_addr_b = '0;
    bus.lk_addr_d = '0;
    drive(1'b1, 5'd3, 32'h1234);

    // 1: reset holds off enqueue
    repeat (3) tick();
    chk("t1_count", 64'(count), 64'd0);
    chk("t1_ready", 64'(bus.wr_ready), 64'd1);
    chk("t1_enable", 64'(bus.rf_enable), 64'd0);
    drive(1'b0, 5'd0, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("t1_idle_count", 64'(count), 64'd0);

    // 2: single write
    drive(1'b1, 5'd5, 32'hDEADBEEF);
    tick();
    drive(1'b0, 5'd0, 32'd0);
    chk("t2_enable", 64'(bus.rf_enable), 64'd1);
    chk("t2_rw", 64'(bus.rf_rw), 64'd5);
    chk("t2_pw", 64'(bus.rf_pw), 64'hDEADBEEF);
    chk("t2_count1", 64'(count), 64'd1);
    tick();
    chk("t2_count0", 64'(count), 64'd0);
    chk("t2_enable0", 64'(bus.rf_enable), 64'd0);

    // 3: fill with hold, reject a fifth, then drain in order
    drain_hold = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 5'(i), 32'(i * 'h11));
      tick();
    end
    drive(1'b0, 5'd0, 32'd0);
    chk("t3_count4", 64'(count), 64'd4);
    chk("t3_ready0", 64'(bus.wr_ready), 64'd0);
    drive(1'b1, 5'd9, 32'h99);
    tick();
    drive(1'b0, 5'd0, 32'd0);
    chk("t3_still4", 64'(count), 64'd4);
    clog.delete();
    drain_hold = 1'b0;
    repeat (4) tick();
    chk("t3_count0", 64'(count), 64'd0);
    chk("t3_ncommit", 64'(clog.size()), 64'd4);
    for (int i = 0; i < 4 && i < clog.size(); i++) begin
      chk("t3_c_addr", 64'(clog[i].addr), 64'(i + 1));
      chk("t3_c_data", 64'(clog[i].data), 64'((i + 1) * 'h11));
    end

    // 4: R0 writes are swallowed
    clog.delete();
    drive(1'b1, 5'd0, 32'hFFFF);
    chk("t4_ready", 64'(bus.wr_ready), 64'd1);
    tick();
    drive(1'b0, 5'd0, 32'd0);
    chk("t4_count", 64'(count), 64'd0);
    chk("t4_hit_a", 64'(bus.lk_hit_a), 64'd0);
    tick();
    chk("t4_nocommit", 64'(clog.size()), 64'd0);

    // 5: bypass returns youngest match
    drain_hold = 1'b1;
    drive(1'b1, 5'd7, 32'hA);
    tick();
    drive(1'b1, 5'd7, 32'hB);
    tick();
    drive(1'b0, 5'd0, 32'd0);
    bus.lk_addr_a = 5'd7;
    bus.lk_addr_b = 5'd7;
    bus.lk_addr_d = 5'd8;
    #1;
    chk("t5_hit_a", 64'(bus.lk_hit_a), 64'd1);
    chk("t5_data_a", 64'(bus.lk_data_a), 64'hB);
    chk("t5_hit_b", 64'(bus.lk_hit_b), 64'd1);
    chk("t5_data_b", 64'(bus.lk_data_b), 64'hB);
    chk("t5_hit_d", 64'(bus.lk_hit_d), 64'd0);
    chk("t5_data_d", 64'(bus.lk_data_d), 64'd0);
    drain_hold = 1'b0;
    tick();
    chk("t5_head_pending", 64'(bus.lk_data_a), 64'hB);
    tick();
    chk("t5_drained", 64'(count), 64'd0);

    // 6: steady enqueue+commit at count 2, pointers wrap, then reset mid-stream
    drain_hold = 1'b1;
    drive(1'b1, 5'd1, 32'h100);
    tick();
    drive(1'b1, 5'd2, 32'h200);
    tick();
    chk("t6_count2", 64'(count), 64'd2);
    clog.delete();
    drain_hold = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 5'(10 + i), 32'h1000 + 32'(i));
      bus.lk_addr_a = 5'(10 + i);
      tick();
      chk("t6_count", 64'(count), 64'd2);
    end
    chk("t6_ncommit", 64'(clog.size()), 64'd10);
    if (clog.size() == 10) begin
      chk("t6_c0", 64'(clog[0]), 64'({5'd1, 32'h100}));
      chk("t6_c1", 64'(clog[1]), 64'({5'd2, 32'h200}));
      for (int i = 2; i < 10; i++)
        chk("t6_cn", 64'(clog[i]), 64'({5'(8 + i), 32'h1000 + 32'(i - 2)}));
    end
    rst_n = 1'b0;
    #1;
    chk("t6_rst_count", 64'(count), 64'd0);
    chk("t6_rst_enable", 64'(bus.rf_enable), 64'd0);
    tick();
    drive(1'b0, 5'd0, 32'd0);
    tick();
    rst_n = 1'b1;
    clog.delete();
    repeat (3) tick();
    chk("t6_no_commit", 64'(clog.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
